// File: rtl/lms_err_monitor.sv
// Windowed MSE monitor for the 4-tap LMS filter: classifies adaptation as
// acquiring, converged or diverged and snapshots the weights on convergence.
module lms_err_monitor #(
    parameter int unsigned WIN_LOG2    = 4,
    parameter logic [15:0] CONV_THRESH = 16'h0029,
    parameter logic [15:0] DIV_THRESH  = 16'h4000,
    parameter int unsigned HOLD_WIN    = 3
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                clr,
    input  logic                en,
    input  logic [15:0]         err_in,
    input  logic [15:0]         w0_in,
    input  logic [15:0]         w1_in,
    input  logic [15:0]         w2_in,
    input  logic [15:0]         w3_in,
    output logic [15:0]         mse_out,
    output logic                mse_valid,
    output logic [1:0]          state_out,
    output logic                converged,
    output logic                diverged,
    output logic [15:0]         w0_snap,
    output logic [15:0]         w1_snap,
    output logic [15:0]         w2_snap,
    output logic [15:0]         w3_snap,
    output logic [WIN_LOG2-1:0] win_cnt
);

    localparam int unsigned DW   = 16;
    localparam int unsigned SQW  = 32;
    localparam int unsigned ACCW = SQW + WIN_LOG2;
    localparam int unsigned GCW  = 4;

    typedef enum logic [1:0] {
        ST_ACQ  = 2'b00,
        ST_CONV = 2'b01,
        ST_DIVG = 2'b10
    } state_t;

    logic [WIN_LOG2-1:0]   win_cnt_q, win_cnt_d;
    logic                  s1_vld_q, s1_vld_d;
    logic [SQW-1:0]        sq_q, sq_d;
    logic                  last_q, last_d;
    logic [3:0][DW-1:0]    w_q, w_d;
    logic [ACCW-1:0]       acc_q, acc_d;
    logic [DW-1:0]         mse_q, mse_d;
    logic                  mse_vld_q, mse_vld_d;
    state_t                state_q, state_d;
    logic [GCW-1:0]        good_q, good_d;
    logic [3:0][DW-1:0]    snap_q, snap_d;
    logic                  conv_q, conv_d;
    logic                  divg_q, divg_d;

    logic signed [SQW-1:0] err_ext_c;
    logic [ACCW-1:0]       sum_c;
    logic [SQW-1:0]        mean_c;
    logic [DW-1:0]         mse_c;

    // Datapath: square, accumulate, mean with saturation to 16 bits
    always_comb begin
        err_ext_c = {{(SQW-DW){err_in[DW-1]}}, err_in};
        sum_c     = acc_q + ACCW'(sq_q);
        mean_c    = sum_c[ACCW-1:WIN_LOG2];
        mse_c     = (mean_c[31:28] != 4'd0) ? 16'hFFFF : mean_c[27:12];
    end

    // Next-state: stage 1 capture, stage 2 window close and classification
    always_comb begin
        win_cnt_d = win_cnt_q;
        s1_vld_d  = en;
        sq_d      = sq_q;
        last_d    = last_q;
        w_d       = w_q;
        acc_d     = acc_q;
        mse_d     = mse_q;
        mse_vld_d = 1'b0;
        state_d   = state_q;
        good_d    = good_q;
        snap_d    = snap_q;

        if (en) begin
            win_cnt_d = win_cnt_q + 1'b1;
            sq_d      = $unsigned(err_ext_c * err_ext_c);
            last_d    = &win_cnt_q;
            w_d       = {w3_in, w2_in, w1_in, w0_in};
        end

        if (s1_vld_q) begin
            acc_d = last_q ? '0 : sum_c;
            if (last_q) begin
                mse_d     = mse_c;
                mse_vld_d = 1'b1;
                if (mse_c >= DIV_THRESH) begin
                    state_d = ST_DIVG;
                end else if (state_q == ST_DIVG) begin
                    state_d = ST_DIVG;
                end else if (mse_c <= CONV_THRESH) begin
                    if (good_q != GCW'(HOLD_WIN)) begin
                        good_d = good_q + 1'b1;
                    end
                    if ((state_q == ST_ACQ) && (good_q + 4'd1 == GCW'(HOLD_WIN))) begin
                        state_d = ST_CONV;
                        snap_d  = w_q;
                    end
                end else begin
                    good_d  = '0;
                    state_d = ST_ACQ;
                end
            end
        end

        conv_d = (state_d == ST_CONV);
        divg_d = (state_d == ST_DIVG);
    end

    // Registers; clr acts exactly like Rst and drops any in-flight sample
    always_ff @(posedge Clk) begin
        if (Rst || clr) begin
            win_cnt_q <= '0;
            s1_vld_q  <= 1'b0;
            sq_q      <= '0;
            last_q    <= 1'b0;
            w_q       <= '0;
            acc_q     <= '0;
            mse_q     <= '0;
            mse_vld_q <= 1'b0;
            state_q   <= ST_ACQ;
            good_q    <= '0;
            snap_q    <= '0;
            conv_q    <= 1'b0;
            divg_q    <= 1'b0;
        end else begin
            win_cnt_q <= win_cnt_d;
            s1_vld_q  <= s1_vld_d;
            sq_q      <= sq_d;
            last_q    <= last_d;
            w_q       <= w_d;
            acc_q     <= acc_d;
            mse_q     <= mse_d;
            mse_vld_q <= mse_vld_d;
            state_q   <= state_d;
            good_q    <= good_d;
            snap_q    <= snap_d;
            conv_q    <= conv_d;
            divg_q    <= divg_d;
        end
    end

    assign mse_out   = mse_q;
    assign mse_valid = mse_vld_q;
    assign state_out = state_q;
    assign converged = conv_q;
    assign diverged  = divg_q;
    assign w0_snap   = snap_q[0];
    assign w1_snap   = snap_q[1];
    assign w2_snap   = snap_q[2];
    assign w3_snap   = snap_q[3];
    assign win_cnt   = win_cnt_q;

endmodule
